// File: rtl/pc_unit.sv
// pc_unit: program-counter and memory-address stage.
// Owns the instruction pointer (PC), data address register (DA) and, when
// PC_EPC_EN is defined, the interrupt return register (EPC). Drives the single
// RAM address and returns PC / link address to the datapath.
// Build option: define PC_EPC_EN to build the EPC register; otherwise epc reads 0.
module pc_unit #(
  parameter int unsigned   AW      = 9,
  parameter int unsigned   DW      = 16,
  parameter logic [AW-1:0] ISR_VEC = 9'h100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reset_pc,
  input  logic          isr_pc,
  input  logic          rsel,
  input  logic          execb,
  input  logic          tsel,
  input  logic          addr_sel,
  input  logic          load_addr,
  input  logic [DW-1:0] sximm8,
  input  logic [DW-1:0] a_out,
  input  logic [DW-1:0] c_out,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] link_addr,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] epc,
  output logic          addr_err
);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] da_q;
  logic          addr_err_q;

  logic [AW-1:0] pc_inc;
  logic [DW-1:0] pc_ext;
  logic [DW-1:0] br_sum;
  logic          a_ovf, c_ovf;
  logic          isr_win, tsel_win;
  logic          unused_br_hi;

  // PC+1 wraps modulo 2^AW; the branch sum is formed at DW width then truncated.
  assign pc_inc       = pc_q + {{(AW-1){1'b0}}, 1'b1};
  assign pc_ext       = {{(DW-AW){1'b0}}, pc_q};
  assign br_sum       = pc_ext + {{(DW-1){1'b0}}, 1'b1} + sximm8;
  assign unused_br_hi = ^br_sum[DW-1:AW];

  assign a_ovf = |a_out[DW-1:AW];
  assign c_ovf = |c_out[DW-1:AW];

  // Which strobe actually wins the PC priority chain (reset handled in the flop).
  assign isr_win  = !reset_pc && isr_pc;
  assign tsel_win = !reset_pc && !isr_pc && !execb && tsel;

  // Next PC by priority: reset_pc > isr_pc > execb > tsel > rsel > hold.
  always_comb begin
    pc_d = pc_q;
    if (reset_pc) begin
      pc_d = '0;
    end else if (isr_pc) begin
      pc_d = ISR_VEC;
    end else if (execb) begin
      pc_d = br_sum[AW-1:0];
    end else if (tsel) begin
      pc_d = a_out[AW-1:0];
    end else if (rsel) begin
      pc_d = pc_inc;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // DA register; independent of the PC chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      da_q <= '0;
    end else if (load_addr) begin
      da_q <= c_out[AW-1:0];
    end
  end

  // Sticky out-of-range flag: only an applied jump target or DA load can set it.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_err_q <= 1'b0;
    end else if ((tsel_win && a_ovf) || (load_addr && c_ovf)) begin
      addr_err_q <= 1'b1;
    end
  end

`ifdef PC_EPC_EN
  logic [AW-1:0] epc_q;

  // Capture the interrupted PC when the ISR vector wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      epc_q <= '0;
    end else if (isr_win) begin
      epc_q <= pc_q;
    end
  end

  assign epc = epc_q;
`else
  logic unused_isr_win;
  assign unused_isr_win = isr_win;
  assign epc            = '0;
`endif

  assign pc        = pc_q;
  assign addr_err  = addr_err_q;
  assign mem_addr  = addr_sel ? pc_q : da_q;
  assign link_addr = {{(DW-AW){1'b0}}, pc_inc};

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboarded bench for pc_unit: a behavioural model predicts each cycle's
// outputs and queues them; a monitor pops and compares after every clock edge.
module tb_pc_unit;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset, reset_pc, isr_pc, rsel, execb, tsel, addr_sel, load_addr;
  logic [DW-1:0] sximm8, a_out, c_out;
  logic [AW-1:0] pc, mem_addr, epc;
  logic [DW-1:0] link_addr;
  logic          addr_err;

  pc_unit #(.AW(AW), .DW(DW), .ISR_VEC(9'h100)) dut (
    .clk       (clk),
    .reset     (reset),
    .reset_pc  (reset_pc),
    .isr_pc    (isr_pc),
    .rsel      (rsel),
    .execb     (execb),
    .tsel      (tsel),
    .addr_sel  (addr_sel),
    .load_addr (load_addr),
    .sximm8    (sximm8),
    .a_out     (a_out),
    .c_out     (c_out),
    .pc        (pc),
    .link_addr (link_addr),
    .mem_addr  (mem_addr),
    .epc       (epc),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int mem_addr;
    int link;
    int epc;
    int err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Staged stimulus, applied at the next falling edge.
  logic          s_reset, s_rpc, s_isr, s_rsel, s_execb, s_tsel, s_asel, s_load;
  int            s_imm, s_a, s_c;

  // Reference state.
  int m_pc = 0, m_da = 0, m_epc = 0, m_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  task automatic clr();
    s_reset = 0; s_rpc = 0; s_isr = 0; s_rsel = 0; s_execb = 0; s_tsel = 0;
    s_asel = 1; s_load = 0; s_imm = 0; s_a = 0; s_c = 0;
  endtask

  // Apply one cycle of stimulus and queue what the DUT must show after the edge.
  task automatic cyc();
    exp_t e;
    int   npc, nda, nepc, nerr;
    @(negedge clk);
    reset = s_reset; reset_pc = s_rpc; isr_pc = s_isr; rsel = s_rsel;
    execb = s_execb; tsel = s_tsel; addr_sel = s_asel; load_addr = s_load;
    sximm8 = s_imm[DW-1:0]; a_out = s_a[DW-1:0]; c_out = s_c[DW-1:0];
    npc = m_pc; nda = m_da; nepc = m_epc; nerr = m_err;
    if (s_reset) begin
      npc = 0; nda = 0; nepc = 0; nerr = 0;
    end else begin
      if (s_rpc)        npc = 0;
      else if (s_isr) begin
        npc = 'h100;
`ifdef PC_EPC_EN
        nepc = m_pc;
`endif
      end
      else if (s_execb) npc = (m_pc + 1 + s_imm) & MASK;
      else if (s_tsel) begin
        npc = s_a & MASK;
        if ((s_a >> AW) != 0) nerr = 1;
      end
      else if (s_rsel)  npc = (m_pc + 1) & MASK;
      if (s_load) begin
        nda = s_c & MASK;
        if ((s_c >> AW) != 0) nerr = 1;
      end
    end
    m_pc = npc; m_da = nda; m_epc = nepc; m_err = nerr;
    e.pc       = m_pc;
    e.mem_addr = s_asel ? m_pc : m_da;
    e.link     = (m_pc + 1) & MASK;
    e.epc      = m_epc;
    e.err      = m_err;
    q.push_back(e);
  endtask

  // Monitor: every edge is an output event; compare against the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("pc", int'(pc), e.pc);
      chk("mem_addr", int'(mem_addr), e.mem_addr);
      chk("link_addr", int'(link_addr), e.link);
      chk("epc", int'(epc), e.epc);
      chk("addr_err", int'(addr_err), e.err);
    end
  end

  initial begin
    reset = 1; reset_pc = 0; isr_pc = 0; rsel = 0; execb = 0; tsel = 0;
    addr_sel = 1; load_addr = 0; sximm8 = '0; a_out = '0; c_out = '0;

    clr(); s_reset = 1; cyc();
    // Three increments from reset.
    for (int i = 0; i < 3; i++) begin clr(); s_rsel = 1; cyc(); end
    // Wrap at the top of the address space.
    clr(); s_tsel = 1; s_a = 'h1FF; cyc();
    clr(); s_rsel = 1; cyc();
    // Negative branch wraps below zero.
    clr(); s_tsel = 1; s_a = 'h005; cyc();
    clr(); s_execb = 1; s_imm = 'hFFF9; cyc();
    // execb beats tsel, then tsel alone.
    clr(); s_tsel = 1; s_a = 'h010; cyc();
    clr(); s_execb = 1; s_tsel = 1; s_imm = 'h0004; s_a = 'h0030; cyc();
    clr(); s_tsel = 1; s_a = 'h0030; cyc();
    // Overflowing DA load, then read DA through mem_addr; flag is sticky.
    clr(); s_load = 1; s_c = 'h0245; s_asel = 0; cyc();
    for (int i = 0; i < 3; i++) begin clr(); s_asel = 0; s_rsel = 1; cyc(); end
    // Interrupt entry paired with rsel.
    clr(); s_tsel = 1; s_a = 'h022; cyc();
    clr(); s_isr = 1; s_rsel = 1; cyc();
    // Reset overrides every other strobe.
    clr(); s_reset = 1; s_execb = 1; s_load = 1; s_isr = 1; s_c = 'h0345; s_imm = 3; cyc();
    // Jump target overflow, combined with an in-range DA load.
    clr(); s_tsel = 1; s_load = 1; s_a = 'h0230; s_c = 'h0077; s_asel = 0; cyc();
    clr(); s_rpc = 1; s_rsel = 1; cyc();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      clr();
      s_reset = ($urandom_range(0, 99) < 3);
      s_rpc   = ($urandom_range(0, 99) < 5);
      s_isr   = ($urandom_range(0, 99) < 8);
      s_rsel  = ($urandom_range(0, 99) < 50);
      s_execb = ($urandom_range(0, 99) < 20);
      s_tsel  = ($urandom_range(0, 99) < 20);
      s_load  = ($urandom_range(0, 99) < 25);
      s_asel  = $urandom_range(0, 1) != 0;
      s_imm   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 127))
                                            : int'($urandom_range('hFF80, 'hFFFF));
      s_a     = ($urandom_range(0, 99) < 15) ? int'($urandom_range(0, 'hFFFF))
                                             : int'($urandom_range(0, MASK));
      s_c     = ($urandom_range(0, 99) < 15) ? int'($urandom_range(0, 'hFFFF))
                                             : int'($urandom_range(0, MASK));
      // Keep a losing jump target in range so the flag depends only on applied jumps.
      if (s_rpc || s_isr || s_execb || !s_tsel) s_a = s_a & MASK;
      cyc();
    end

    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d predictions left, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
